// File: rtl/wb_intercon_n.sv
// Shared-bus Wishbone interconnect: N masters arbitrated onto one bus, M slaves decoded by base/mask.
// Latency: one cycle from cyc to grant; slave responses route back to the master with zero latency.
// Backpressure: the grant holds while the owner keeps cyc high, and other masters wait un-answered.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_sel_i/m_we_i  flattened master request fields (master i in field i)
//   m_cyc_i/m_stb_i               per-master cycle / strobe
//   m_dat_o                       read data shared by all masters
//   m_ack_o/m_err_o/m_rty_o       per-master responses, only the granted bit can be set
//   s_adr_o/s_dat_o/s_sel_o/s_we_o  granted master's request, broadcast to every slave
//   s_cyc_o/s_stb_o               per-slave cycle / strobe, only the decoded slave is driven
//   s_dat_i/s_ack_i/s_err_i/s_rty_i per-slave read data and responses
//   busy_o                        high while a master owns the bus
module wb_intercon_n #(
    parameter int                          n_masters = 2,
    parameter int                          n_slaves  = 8,
    parameter int                          adr_w     = 32,
    parameter int                          dat_w     = 32,
    parameter logic [n_slaves*adr_w-1:0]   slv_base  = '0,
    parameter logic [n_slaves*adr_w-1:0]   slv_mask  = '0,
    parameter bit                          arb_rr    = 1'b1,
    parameter int                          timeout   = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic [n_masters*adr_w-1:0]      m_adr_i,
    input  logic [n_masters*dat_w-1:0]      m_dat_i,
    input  logic [n_masters*dat_w/8-1:0]    m_sel_i,
    input  logic [n_masters-1:0]            m_we_i,
    input  logic [n_masters-1:0]            m_cyc_i,
    input  logic [n_masters-1:0]            m_stb_i,
    output logic [dat_w-1:0]                m_dat_o,
    output logic [n_masters-1:0]            m_ack_o,
    output logic [n_masters-1:0]            m_err_o,
    output logic [n_masters-1:0]            m_rty_o,

    output logic [adr_w-1:0]                s_adr_o,
    output logic [dat_w-1:0]                s_dat_o,
    output logic [dat_w/8-1:0]              s_sel_o,
    output logic                            s_we_o,
    output logic [n_slaves-1:0]             s_cyc_o,
    output logic [n_slaves-1:0]             s_stb_o,
    input  logic [n_slaves*dat_w-1:0]       s_dat_i,
    input  logic [n_slaves-1:0]             s_ack_i,
    input  logic [n_slaves-1:0]             s_err_i,
    input  logic [n_slaves-1:0]             s_rty_i,

    output logic                            busy_o
);

    localparam int sel_w = dat_w / 8;
    localparam int mi_w  = (n_masters > 1) ? $clog2(n_masters) : 1;
    localparam int si_w  = (n_slaves > 1) ? $clog2(n_slaves) : 1;
    localparam int wd_w  = $clog2(timeout + 2);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t             state;
    logic [mi_w-1:0]    gnt;
    logic [mi_w-1:0]    rr_ptr;
    logic [wd_w-1:0]    wd_cnt;
    logic               miss_err;
    logic               miss_done;

    logic               busy;
    logic [adr_w-1:0]   g_adr;
    logic               g_cyc;
    logic               g_stb;
    logic               hit;
    logic [si_w-1:0]    slv;
    logic               sl_ack;
    logic               sl_err;
    logic               sl_rty;
    logic               resp;
    logic               wd_fire;
    logic [mi_w-1:0]    winner;
    logic               found;
    int                 rr_idx;

    assign busy  = (state == BUSY);
    assign g_adr = m_adr_i[gnt*adr_w +: adr_w];
    assign g_cyc = busy && m_cyc_i[gnt];
    assign g_stb = busy && m_stb_i[gnt];

    // Address decode: walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        slv = '0;
        for (int i = n_slaves - 1; i >= 0; i--) begin
            if ((g_adr & slv_mask[i*adr_w +: adr_w]) == slv_base[i*adr_w +: adr_w]) begin
                hit = 1'b1;
                slv = si_w'(i);
            end
        end
    end

    assign sl_ack = hit && s_ack_i[slv];
    assign sl_err = hit && s_err_i[slv];
    assign sl_rty = hit && s_rty_i[slv];
    assign resp   = sl_ack || sl_err || sl_rty;

    // Watchdog only guards decoded slaves; a miss is answered by its own one-shot err.
    // Any real slave response in the expiry cycle wins over the timeout.
    assign wd_fire = (timeout != 0) && g_stb && hit && !resp && (wd_cnt == wd_w'(timeout));

    // Arbitration: round-robin searches upwards from the slot after the last winner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        if (arb_rr) begin
            for (int k = 1; k <= n_masters; k++) begin
                rr_idx = (int'(rr_ptr) + k) % n_masters;
                if (!found && m_cyc_i[rr_idx]) begin
                    winner = mi_w'(rr_idx);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = n_masters - 1; i >= 0; i--) begin
                if (m_cyc_i[i]) begin
                    winner = mi_w'(i);
                end
            end
        end
    end

    // Bus outputs: everything is gated by the BUSY state so an idle or reset bus reads all zero.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = '0;
        s_stb_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (busy) begin
            s_adr_o = g_adr;
            s_dat_o = m_dat_i[gnt*dat_w +: dat_w];
            s_sel_o = m_sel_i[gnt*sel_w +: sel_w];
            s_we_o  = m_we_i[gnt];
            if (hit) begin
                s_cyc_o[slv] = g_cyc;
                s_stb_o[slv] = g_stb && !wd_fire;
                m_dat_o      = s_dat_i[slv*dat_w +: dat_w];
            end
            m_ack_o[gnt] = sl_ack;
            m_err_o[gnt] = sl_err || miss_err || wd_fire;
            m_rty_o[gnt] = sl_rty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            gnt       <= '0;
            rr_ptr    <= mi_w'(n_masters - 1);
            wd_cnt    <= '0;
            miss_err  <= 1'b0;
            miss_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        state  <= BUSY;
                        busy_o <= 1'b1;
                        gnt    <= winner;
                        if (arb_rr) begin
                            rr_ptr <= winner;
                        end
                    end
                end
                BUSY: begin
                    if (!m_cyc_i[gnt]) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase

            if (!g_stb || !hit || resp || wd_fire || timeout == 0) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            // One err per missed strobe: miss_done blocks re-arming until stb drops.
            miss_err  <= g_stb && !hit && !miss_done && !miss_err;
            miss_done <= g_stb && (miss_done || miss_err);
        end
    end

endmodule

// File: tb/tb_wb_intercon_n.sv
module tb_wb_intercon_n;

    localparam logic [127:0] BASE = {32'h7000_0000, 32'h7001_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] MASK = {32'hFF00_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};
    localparam logic [31:0]  A0   = 32'h0000_0010;
    localparam logic [31:0]  A1   = 32'h1000_0020;

    logic        clk;
    logic        rst_n;
    logic [31:0] madr[2];
    logic [31:0] mdat[2];
    logic [3:0]  msel[2];
    logic [1:0]  mwe, mcyc, mstb;
    logic [3:0]  sack, serr, srty;

    logic [63:0]  m_adr, m_dat;
    logic [7:0]   m_sel;
    logic [127:0] s_dat;

    assign m_adr = {madr[1], madr[0]};
    assign m_dat = {mdat[1], mdat[0]};
    assign m_sel = {msel[1], msel[0]};
    assign s_dat = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_A000};

    logic [31:0] m_dat_o, s_adr_o, s_dat_o;
    logic [1:0]  m_ack_o, m_err_o, m_rty_o;
    logic [3:0]  s_sel_o, s_cyc_o, s_stb_o;
    logic        s_we_o, busy_o;

    logic [31:0] fp_m_dat_o, fp_s_adr_o, fp_s_dat_o;
    logic [1:0]  fp_m_ack_o, fp_m_err_o, fp_m_rty_o;
    logic [3:0]  fp_s_sel_o, fp_s_cyc_o, fp_s_stb_o;
    logic        fp_s_we_o, fp_busy_o;

    wb_intercon_n #(.n_masters(2), .n_slaves(4), .adr_w(32), .dat_w(32),
                    .slv_base(BASE), .slv_mask(MASK), .arb_rr(1'b1), .timeout(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(mwe),
        .m_cyc_i(mcyc), .m_stb_i(mstb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat), .s_ack_i(sack), .s_err_i(serr), .s_rty_i(srty),
        .busy_o(busy_o));

    wb_intercon_n #(.n_masters(2), .n_slaves(4), .adr_w(32), .dat_w(32),
                    .slv_base(BASE), .slv_mask(MASK), .arb_rr(1'b0), .timeout(4)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(mwe),
        .m_cyc_i(mcyc), .m_stb_i(mstb),
        .m_dat_o(fp_m_dat_o), .m_ack_o(fp_m_ack_o), .m_err_o(fp_m_err_o), .m_rty_o(fp_m_rty_o),
        .s_adr_o(fp_s_adr_o), .s_dat_o(fp_s_dat_o), .s_sel_o(fp_s_sel_o), .s_we_o(fp_s_we_o),
        .s_cyc_o(fp_s_cyc_o), .s_stb_o(fp_s_stb_o),
        .s_dat_i(s_dat), .s_ack_i(sack), .s_err_i(serr), .s_rty_i(srty),
        .busy_o(fp_busy_o));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: got no finish, expected finish before 200000");
        $fatal(1, "time limit");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mcyc = '0; mstb = '0; mwe = '0;
        sack = '0; serr = '0; srty = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  ack, err, rty, exp_stb;
        logic [1:0]  exp_ack, exp_err, exp_rty;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{32'h0000_0010, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'b01, 2'b00, 2'b00, 32'h0000_A000};
        vt[1] = '{32'h1000_0004, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 2'b00, 2'b01, 2'b00, 32'h1111_1111};
        vt[2] = '{32'h1000_0008, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 2'b00, 2'b00, 2'b01, 32'h1111_1111};
        vt[3] = '{32'h7001_0004, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'b01, 2'b00, 2'b00, 32'hDEAD_BEEF};
        vt[4] = '{32'h7001_0004, 4'b1000, 4'b0001, 4'b0000, 4'b0100, 2'b00, 2'b00, 2'b00, 32'hDEAD_BEEF};
        vt[5] = '{32'h7020_0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'b01, 2'b00, 2'b00, 32'h3333_3333};
        vt[6] = '{32'h5000_0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 2'b00, 2'b00, 2'b00, 32'h0000_0000};
        vt[7] = '{32'hF000_0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 32'h0000_0000};

        madr[0] = A0; madr[1] = A1;
        mdat[0] = 32'h0123_4567; mdat[1] = 32'hCAFE_F00D;
        msel[0] = 4'hF; msel[1] = 4'h3;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_m_ack", m_ack_o, 0);
        chk("rst_s_adr", s_adr_o, 0);

        // Single read from slave 2, ack two cycles after the strobe reaches it
        step(); madr[0] = 32'h7001_0004; mcyc[0] = 1; mstb[0] = 1;
        @(negedge clk);
        chk("t1_idle_stb", s_stb_o, 0);
        step(); @(negedge clk);
        chk("t1_busy", busy_o, 1);
        chk("t1_s_stb", s_stb_o, 4'b0100);
        chk("t1_s_cyc", s_cyc_o, 4'b0100);
        chk("t1_noack", m_ack_o, 0);
        step(); @(negedge clk);
        chk("t1_noack2", m_ack_o, 0);
        step(); sack = 4'b0100; @(negedge clk);
        chk("t1_ack", m_ack_o, 2'b01);
        chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
        chk("t1_noerr", m_err_o, 0);
        step(); sack = 0; mcyc[0] = 0; mstb[0] = 0; @(negedge clk);
        chk("t1_cyc_drop", s_cyc_o, 0);
        chk("t1_still_busy", busy_o, 1);
        step(); @(negedge clk);
        chk("t1_idle", busy_o, 0);

        // Decode table with m0 holding the bus
        mcyc[0] = 1; madr[0] = 0;
        step(); step();
        for (int v = 0; v < 8; v++) begin
            madr[0] = vt[v].adr; mstb[0] = 1;
            sack = vt[v].ack; serr = vt[v].err; srty = vt[v].rty;
            @(negedge clk);
            chk($sformatf("vec%0d_stb", v), s_stb_o, vt[v].exp_stb);
            chk($sformatf("vec%0d_ack", v), m_ack_o, vt[v].exp_ack);
            chk($sformatf("vec%0d_err", v), m_err_o, vt[v].exp_err);
            chk($sformatf("vec%0d_rty", v), m_rty_o, vt[v].exp_rty);
            chk($sformatf("vec%0d_dat", v), m_dat_o, vt[v].exp_dat);
            chk($sformatf("vec%0d_adr", v), s_adr_o, vt[v].adr);
            step();
            mstb[0] = 0; sack = 0; serr = 0; srty = 0;
            step();
        end
        mcyc[0] = 0;
        step();

        // Fixed priority: m1 waits for m0's cyc drop plus a dead cycle
        do_reset();
        madr[0] = A0; madr[1] = A1;
        mcyc = 2'b11; mstb = 2'b11;
        step(); sack = 4'b0011; @(negedge clk);
        chk("t2_fp_adr", fp_s_adr_o, A0);
        chk("t2_rr_adr", s_adr_o, A0);
        chk("t2_fp_ack", fp_m_ack_o, 2'b01);
        chk("t2_fp_cyc", fp_s_cyc_o, 4'b0001);
        step(); sack = 0; mcyc[0] = 0; mstb[0] = 0; @(negedge clk);
        chk("t2_fp_busy_drop", fp_busy_o, 1);
        chk("t2_fp_cyc_drop", fp_s_cyc_o, 0);
        step(); @(negedge clk);
        chk("t2_fp_dead", fp_busy_o, 0);
        step(); @(negedge clk);
        chk("t2_fp_m1_adr", fp_s_adr_o, A1);
        chk("t2_fp_m1_cyc", fp_s_cyc_o, 4'b0010);
        step(); mcyc = 0; mstb = 0;
        step();

        // Round-robin alternation vs fixed priority with both masters requesting
        for (int r = 0; r < 4; r++) begin
            mcyc = 2'b11; mstb = 2'b11;
            step(); sack = 4'b0011; @(negedge clk);
            chk($sformatf("rr%0d_adr", r), s_adr_o, (r % 2) ? A1 : A0);
            chk($sformatf("rr%0d_ack", r), m_ack_o, (r % 2) ? 2'b10 : 2'b01);
            chk($sformatf("rr%0d_fp_adr", r), fp_s_adr_o, A0);
            step(); mcyc = 0; mstb = 0; sack = 0;
            step(); @(negedge clk);
            chk($sformatf("rr%0d_idle", r), busy_o, 0);
        end

        // Decode miss write from m1
        madr[1] = 32'h5000_0000; mcyc[1] = 1; mstb[1] = 1; mwe[1] = 1;
        step(); @(negedge clk);
        chk("t4_stb", s_stb_o, 0);
        chk("t4_err0", m_err_o, 0);
        chk("t4_we", s_we_o, 1);
        chk("t4_wdat", s_dat_o, 32'hCAFE_F00D);
        step(); @(negedge clk);
        chk("t4_err", m_err_o, 2'b10);
        chk("t4_fp_err", fp_m_err_o, 2'b10);
        for (int c = 0; c < 6; c++) begin
            step(); @(negedge clk);
            chk($sformatf("t4_noerr%0d", c), m_err_o, 0);
            chk($sformatf("t4_stb%0d", c), s_stb_o, 0);
        end
        step(); mcyc = 0; mstb = 0; mwe = 0; madr[1] = A1;
        step();

        // Watchdog on slave 1 that never answers, then ack exactly at expiry
        madr[0] = 32'h1000_0000; mcyc[0] = 1; mstb[0] = 1;
        step();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("wd_stb%0d", c), s_stb_o, 4'b0010);
            chk($sformatf("wd_noerr%0d", c), m_err_o, 0);
            step();
        end
        @(negedge clk);
        chk("wd_err", m_err_o, 2'b01);
        chk("wd_stb_forced", s_stb_o, 0);
        step();
        for (int c = 6; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("wd_stb%0d", c), s_stb_o, 4'b0010);
            chk($sformatf("wd_noerr%0d", c), m_err_o, 0);
            step();
        end
        sack = 4'b0010; @(negedge clk);
        chk("wd_ack_win", m_ack_o, 2'b01);
        chk("wd_ack_noerr", m_err_o, 0);
        chk("wd_ack_stb", s_stb_o, 4'b0010);
        step(); mcyc = 0; mstb = 0; sack = 0;
        step();

        // Asynchronous reset in the middle of a burst
        madr[0] = 32'h7001_0004; mcyc[0] = 1; mstb[0] = 1;
        step(); sack = 4'b0100; @(negedge clk);
        chk("t6_ack_before", m_ack_o, 2'b01);
        #1 mcyc[1] = 1; mstb[1] = 1; rst_n = 1'b0;
        #1;
        chk("t6_rst_cyc", s_cyc_o, 0);
        chk("t6_rst_ack", m_ack_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_adr", s_adr_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_idle", busy_o, 0);
        step(); @(negedge clk);
        chk("t6_m0_wins", s_adr_o, 32'h7001_0004);
        chk("t6_m0_ack", m_ack_o, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_intercon_n.md
Name: wb_intercon_n

Overview:
- Parametrised shared-bus Wishbone interconnect for LM32 SoCs. Next generation of the fixed 8x8 conbus.
- Supports configurable master and slave counts.
- Slaves are decoded by base/mask instead of fixed top-bit fields.
- Arbitration is fixed-priority or round-robin.
- A watchdog returns err on decode misses and on hung slaves.
- Sits between the lm32 I/D ports (plus optional DMA masters) and the bram, sram, uart, timer, gpio and farbborg slaves.

Parameters:
- n_masters, 2, number of masters (1..8).
- n_slaves, 8, number of slaves (1..16).
- adr_w, 32, address width.
- dat_w, 32, data width; sel width is dat_w/8.
- slv_base, {n_slaves{32'h0}}, flattened n_slaves*adr_w base addresses; slave i occupies field i.
- slv_mask, {n_slaves{32'h0}}, flattened n_slaves*adr_w masks; slave i matches when (adr & mask_i) == base_i.
- arb_rr, 1, 0 = fixed priority (master 0 highest), 1 = round-robin.
- timeout, 255, cycles of unanswered stb before err is returned; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_adr_i  in  n_masters*adr_w  master addresses.
- m_dat_i  in  n_masters*dat_w  master write data.
- m_sel_i  in  n_masters*dat_w/8  master byte selects.
- m_we_i  in  n_masters  master write enables.
- m_cyc_i  in  n_masters  master cycle.
- m_stb_i  in  n_masters  master strobe.
- m_dat_o  out  dat_w  read data, shared by all masters.
- m_ack_o  out  n_masters  ack, granted master only.
- m_err_o  out  n_masters  err, granted master only.
- m_rty_o  out  n_masters  rty, granted master only.
- s_adr_o  out  adr_w  address broadcast from the granted master.
- s_dat_o  out  dat_w  write data broadcast from the granted master.
- s_sel_o  out  dat_w/8  byte selects broadcast from the granted master.
- s_we_o  out  1  write enable broadcast from the granted master.
- s_cyc_o  out  n_slaves  cycle, decoded slave only.
- s_stb_o  out  n_slaves  strobe, decoded slave only.
- s_dat_i  in  n_slaves*dat_w  slave read data.
- s_ack_i  in  n_slaves  slave ack.
- s_err_i  in  n_slaves  slave err.
- s_rty_i  in  n_slaves  slave rty.
- busy_o  out  1  high while a master is granted.

Behaviour:

Reset:
- rst_n low asynchronously returns the FSM to IDLE, clears the grant and the watchdog, and sets the rr pointer to n_masters-1 so master 0 wins first.
- All m_ack/err/rty, s_cyc/stb and busy_o read 0. Broadcast buses read 0.
- Reset mid-transfer aborts the transfer; the slave sees cyc drop immediately.

FSM IDLE:
- If any m_cyc_i is high, latch the winner on the next edge and go to BUSY.
- Fixed mode: lowest index wins.
- RR mode: search starts at rr_ptr+1, wraps modulo n_masters, and rr_ptr is updated to the winner.
- No bus outputs are asserted in IDLE.

FSM BUSY:
- Granted master's adr/dat/sel/we drive s_* combinationally.
- Slave index = lowest i whose match holds.
- s_cyc_o[i] = m_cyc, s_stb_o[i] = m_stb of the granted master.
- Slave ack/err/rty route combinationally (zero latency) to the granted master's bit.
- m_dat_o = s_dat_i of the decoded slave, or 0 on a miss.
- Grant holds while the granted m_cyc_i stays high; this covers bursts and RMW sequences, and other requests wait.
- Granted cyc low -> IDLE on the next edge. One dead cycle is spent between grants.
- busy_o = (state == BUSY).

Decode miss:
- stb high with no match -> no s_stb asserted.
- m_err_o is pulsed one cycle later, for exactly one cycle per strobe, and is not repeated while the same stb stays high after the err.

Watchdog:
- Counter clears when stb is low or on any ack/err/rty, otherwise it increments while stb is high.
- At count == timeout, m_err_o pulses for 1 cycle and the counter clears.
- The slave's s_stb is forced low during that err cycle.
- A slave ack arriving in the same cycle as the timeout takes priority (ack passes, no err).
- timeout = 0 never fires.

Other rules:
- Multiple slave matches: lowest index wins, with no error.
- Requests from non-granted masters are ignored and get no response.
- A master dropping cyc while its ack is high completes normally.

Test Plan:
1. Single master, slave 2 at base 0x70010000 / mask 0xFFFF0000: m0 reads 0x70010004 with slave ack after 2 cycles and data 0xDEADBEEF -> s_stb_o[2]=1 from cycle 1; m_ack_o[0] in the same cycle as s_ack_i[2]; m_dat_o=0xDEADBEEF; return to IDLE 1 cycle after cyc drops.
2. Fixed priority: m0 and m1 both request in IDLE -> m0 granted; m1 granted only in the cycle after m0's cyc drops plus one dead cycle.
3. Round-robin, both masters requesting continuously with 1-transfer cycles -> grants alternate 0,1,0,1; the first grant after reset goes to m0.
4. Decode miss: m1 writes 0x50000000 with no slave matching -> every s_stb_o stays 0; m_err_o[1] pulses 1 cycle, 1 cycle after stb.
5. Watchdog with timeout=4 and a slave never acking -> m_err_o pulses after 4 cycles of stb; s_stb drops in that cycle. With the ack in the same cycle as the expiry -> ack only, no err.
6. rst_n pulsed low mid-burst -> s_cyc_o/m_ack_o go 0 immediately without a clock edge; after release, m0 wins the first arbitration.
